// File: rtl/relay_pkg.sv
// Shared constants and sizing helpers for the credit-based relay station.
package relay_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 2;
    localparam int unsigned DEF_LEVEL      = 2;
    localparam int unsigned DEF_CONNECT    = 1;

    // Receive FIFOs at or above this many entries use a pointer-addressed RAM array.
    localparam int unsigned RAM_THRESHOLD  = 128;

    // Credits cover the full round trip (LEVEL out, LEVEL back, plus the two
    // registered hops at the counter and the FIFO) plus the extra buffering.
    function automatic int unsigned calc_credits(input int unsigned depth,
                                                 input int unsigned level);
        return depth + 2 * level + 2;
    endfunction

    function automatic int unsigned calc_cnt_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/relay_credit_fifo.sv
// First-word fall-through receive FIFO with occupancy and sticky overflow flag.
module relay_credit_fifo import relay_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned CNT_WIDTH = calc_cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    output logic                  o_empty_n,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_full   = (r_count == CNT_WIDTH'(DEPTH));
    assign w_wr_acc = i_wr & ~w_full;
    assign w_rd_acc = i_rd & (r_count != '0);

    // Occupancy tracking; a write into a full FIFO is dropped and flagged forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= r_count + CNT_WIDTH'(w_wr_acc) - CNT_WIDTH'(w_rd_acc);
            if (i_wr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    if (DEPTH < RAM_THRESHOLD) begin : g_shift
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]         w_wr_idx;

        // When popping, the write lands one slot lower because everything shifts down.
        assign w_wr_idx = w_rd_acc ? AW'(r_count - CNT_WIDTH'(1)) : AW'(r_count);

        // Head lives in slot 0; pops shift the array toward it.
        always_ff @(posedge clk) begin
            if (w_rd_acc) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    r_mem[i] <= r_mem[i + 1];
                end
            end
            if (w_wr_acc) begin
                r_mem[w_wr_idx] <= i_wdata;
            end
        end

        assign w_head = r_mem[0];
    end else begin : g_ram
        logic [DATA_WIDTH-1:0] r_ram [DEPTH];
        logic [AW-1:0]         r_wr_ptr;
        logic [AW-1:0]         r_rd_ptr;

        // Circular read/write pointers wrapping at DEPTH.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
                end
            end
        end

        // Storage array, write port only.
        always_ff @(posedge clk) begin
            if (w_wr_acc) begin
                r_ram[r_wr_ptr] <= i_wdata;
            end
        end

        assign w_head = r_ram[r_rd_ptr];
    end

    assign o_empty_n  = (r_count != '0);
    assign o_rdata    = o_empty_n ? w_head : '0;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/relay_station_credit.sv
// Credit-based relay station: write-side credit counter, LEVEL-stage forward
// pipe, FWFT receive FIFO and LEVEL-stage credit return pipe.
module relay_station_credit import relay_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned LEVEL      = DEF_LEVEL,
    parameter int unsigned CONNECT    = DEF_CONNECT,
    localparam int unsigned CREDITS   = calc_credits(DEPTH, LEVEL),
    localparam int unsigned CNT_WIDTH = calc_cnt_width(CREDITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [CNT_WIDTH-1:0]  if_count,
    output logic                  err_overflow
);

    if (CONNECT != 0) begin : g_link
        logic [CNT_WIDTH-1:0]  r_cnt;
        logic [CNT_WIDTH-1:0]  w_cnt_next;
        logic                  w_push;
        logic                  w_pop;
        logic                  w_credit_ret;
        logic                  w_fifo_wr;
        logic [DATA_WIDTH-1:0] w_fifo_din;
        logic                  w_empty_n;

        // full_n is decoded purely from the counter register.
        assign if_full_n  = (r_cnt != '0);
        assign w_push     = if_write & if_write_ce & if_full_n;
        assign w_pop      = if_read & if_read_ce & w_empty_n;
        assign if_empty_n = w_empty_n;
        assign w_cnt_next = r_cnt - CNT_WIDTH'(w_push) + CNT_WIDTH'(w_credit_ret);

        // Credit counter: one credit spent per push, one restored per returned token.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= CNT_WIDTH'(CREDITS);
            end else begin
                r_cnt <= w_cnt_next;
            end
        end

        // Credit bounds: never spend without a credit, never exceed CREDITS.
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (!(w_push && (r_cnt == '0)));
                assert (int'(r_cnt) + int'(w_credit_ret) <= int'(CREDITS) + int'(w_push));
            end
        end

        if (LEVEL == 0) begin : g_direct
            assign w_fifo_wr    = w_push;
            assign w_fifo_din   = if_din;
            assign w_credit_ret = w_pop;
        end else begin : g_piped
            for (genvar g = 0; g < LEVEL; g++) begin : g_stage
                logic                  r_vld;
                logic                  r_ret;
                logic [DATA_WIDTH-1:0] r_data;
                logic                  w_vld_in;
                logic                  w_ret_in;
                logic [DATA_WIDTH-1:0] w_data_in;

                if (g == 0) begin : g_first
                    assign w_vld_in  = w_push;
                    assign w_data_in = if_din;
                    assign w_ret_in  = w_pop;
                end else begin : g_next
                    assign w_vld_in  = g_stage[g - 1].r_vld;
                    assign w_data_in = g_stage[g - 1].r_data;
                    assign w_ret_in  = g_stage[g - 1].r_ret;
                end

                // Forward valid and return token bits; the only pipe state that resets.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld <= 1'b0;
                        r_ret <= 1'b0;
                    end else begin
                        r_vld <= w_vld_in;
                        r_ret <= w_ret_in;
                    end
                end

                // Free-running data stage, qualified downstream by r_vld.
                always_ff @(posedge clk) begin
                    r_data <= w_data_in;
                end
            end

            assign w_fifo_wr    = g_stage[LEVEL - 1].r_vld;
            assign w_fifo_din   = g_stage[LEVEL - 1].r_data;
            assign w_credit_ret = g_stage[LEVEL - 1].r_ret;
        end

        relay_credit_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (CREDITS)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .i_wr       (w_fifo_wr),
            .i_wdata    (w_fifo_din),
            .i_rd       (w_pop),
            .o_empty_n  (w_empty_n),
            .o_rdata    (if_dout),
            .o_count    (if_count),
            .o_overflow (err_overflow)
        );
    end else begin : g_open
        // Disconnected link: no state, all outputs idle.
        logic w_unused;
        assign w_unused     = ^{clk, reset, if_write_ce, if_write, if_din, if_read_ce, if_read};
        assign if_full_n    = 1'b0;
        assign if_empty_n   = 1'b0;
        assign if_dout      = '0;
        assign if_count     = '0;
        assign err_overflow = 1'b0;
    end

endmodule

// File: tb/tb_relay_station_credit.sv
// Self-checking bench: behavioural credit/latency model plus data scoreboard for
// the default build, directed checks for LEVEL=0 and CONNECT=0 builds.
module tb_relay_station_credit;

    localparam int DW        = 32;
    localparam int A_DEPTH   = 2;
    localparam int A_LEVEL   = 2;
    localparam int A_CREDITS = A_DEPTH + 2 * A_LEVEL + 2;
    localparam int A_CW      = $clog2(A_CREDITS + 1);
    localparam int B_LEVEL   = 0;
    localparam int B_CREDITS = 2 + 2 * B_LEVEL + 2;
    localparam int B_CW      = $clog2(B_CREDITS + 1);

    logic clk = 1'b0;
    logic reset, b_reset;
    int   cyc = 0;

    logic          a_write_ce, a_write, a_read_ce, a_read;
    logic [DW-1:0] a_din, a_dout;
    logic          a_full_n, a_empty_n, a_err;
    logic [A_CW-1:0] a_count;

    logic          b_write_ce, b_write, b_read_ce, b_read;
    logic [DW-1:0] b_din, b_dout;
    logic          b_full_n, b_empty_n, b_err;
    logic [B_CW-1:0] b_count;

    logic          c_write_ce, c_write, c_read_ce, c_read;
    logic [DW-1:0] c_din, c_dout;
    logic          c_full_n, c_empty_n, c_err;
    logic [A_CW-1:0] c_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relay_station_credit #(.DATA_WIDTH(DW), .DEPTH(A_DEPTH), .LEVEL(A_LEVEL), .CONNECT(1)) u_dut_a (
        .clk(clk), .reset(reset), .if_full_n(a_full_n), .if_write_ce(a_write_ce),
        .if_write(a_write), .if_din(a_din), .if_empty_n(a_empty_n), .if_read_ce(a_read_ce),
        .if_read(a_read), .if_dout(a_dout), .if_count(a_count), .err_overflow(a_err)
    );

    relay_station_credit #(.DATA_WIDTH(DW), .DEPTH(2), .LEVEL(B_LEVEL), .CONNECT(1)) u_dut_b (
        .clk(clk), .reset(b_reset), .if_full_n(b_full_n), .if_write_ce(b_write_ce),
        .if_write(b_write), .if_din(b_din), .if_empty_n(b_empty_n), .if_read_ce(b_read_ce),
        .if_read(b_read), .if_dout(b_dout), .if_count(b_count), .err_overflow(b_err)
    );

    relay_station_credit #(.DATA_WIDTH(DW), .DEPTH(2), .LEVEL(2), .CONNECT(0)) u_dut_c (
        .clk(clk), .reset(reset), .if_full_n(c_full_n), .if_write_ce(c_write_ce),
        .if_write(c_write), .if_din(c_din), .if_empty_n(c_empty_n), .if_read_ce(c_read_ce),
        .if_read(c_read), .if_dout(c_dout), .if_count(c_count), .err_overflow(c_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: words in flight with arrival cycle, visible FIFO
    // contents, pending credit returns, and the scoreboard of accepted words.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } fly_t;

    fly_t          fly[$];
    int            ret_q[$];
    logic [DW-1:0] vis[$];
    logic [DW-1:0] sb[$];
    int            credits  = A_CREDITS;
    bit            model_en = 1'b0;

    // Model: push visible LEVEL+1 cycles later, credit back LEVEL+1 cycles after a pop.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en) begin
                while (fly.size() > 0 && fly[0].t <= cyc) begin
                    vis.push_back(fly[0].d);
                    fly.delete(0);
                end
                while (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                    credits++;
                    ret_q.delete(0);
                end
                chk("model_full_n", 32'(a_full_n), 32'(credits > 0));
                chk("model_empty_n", 32'(a_empty_n), 32'(vis.size() > 0));
                chk("model_count", 32'(a_count), 32'(vis.size()));
                chk("model_overflow", 32'(a_err), 32'(0));
                if (vis.size() == 0) chk("model_dout_idle", a_dout, 32'(0));
                if (reset) begin
                    fly.delete();
                    ret_q.delete();
                    vis.delete();
                    sb.delete();
                    credits = A_CREDITS;
                end else begin
                    if (a_write && a_write_ce && credits > 0) begin
                        credits--;
                        fly.push_back('{a_din, cyc + A_LEVEL + 1});
                        sb.push_back(a_din);
                    end
                    if (a_read && a_read_ce && vis.size() > 0) begin
                        vis.delete(0);
                        ret_q.push_back(cyc + A_LEVEL + 1);
                    end
                end
            end
        end
    end

    // Monitor: every DUT pop must deliver the oldest accepted word.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && !reset && a_empty_n && a_read && a_read_ce) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_spurious: got word 0x%0h, expected none (cycle %0d)",
                             a_dout, cyc);
                end else begin
                    chk("sb_data", a_dout, sb[0]);
                    sb.delete(0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int t0, lat, acc, ncyc, rd_pct;
    logic [DW-1:0] val;

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        a_write_ce = 0; a_write = 0; a_din = '0; a_read_ce = 0; a_read = 0;
        b_write_ce = 0; b_write = 0; b_din = '0; b_read_ce = 0; b_read = 0;
        c_write_ce = 0; c_write = 0; c_din = '0; c_read_ce = 0; c_read = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; b_reset = 1'b0; model_en = 1'b1;

        // Reset then idle.
        repeat (3) @(negedge clk);
        chk("idle_full_n", 32'(a_full_n), 32'(1));
        chk("idle_empty_n", 32'(a_empty_n), 32'(0));
        chk("idle_count", 32'(a_count), 32'(0));
        chk("idle_dout", a_dout, 32'(0));
        chk("idle_overflow", 32'(a_err), 32'(0));

        // Single word: latency LEVEL+1, then pop empties the FIFO.
        @(posedge clk); #1 a_write = 1; a_write_ce = 1; a_din = 32'hDEADBEEF;
        @(negedge clk); t0 = cyc;
        @(posedge clk); #1 a_write = 0;
        lat = 0;
        while (!a_empty_n && lat < 20) begin
            @(negedge clk); lat = cyc - t0;
        end
        chk("single_latency", 32'(lat), 32'(A_LEVEL + 1));
        chk("single_dout", a_dout, 32'hDEADBEEF);
        @(posedge clk); #1 a_read = 1; a_read_ce = 1;
        @(posedge clk); #1 a_read = 0;
        @(negedge clk);
        chk("single_pop_empty", 32'(a_empty_n), 32'(0));

        // Back-pressure: stalled reader, writer pushes every cycle.
        repeat (10) @(posedge clk);
        #1 a_write = 1; a_din = 32'h100;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); if (a_full_n) acc++;
            @(posedge clk); #1 a_din = a_din + 1;
        end
        @(negedge clk);
        chk("bp_accepted", 32'(acc), 32'(A_CREDITS));
        chk("bp_count", 32'(a_count), 32'(A_CREDITS));
        chk("bp_full_n", 32'(a_full_n), 32'(0));

        // Credit return meets a held push request while cnt=0.
        @(posedge clk); #1 a_read = 1;
        @(negedge clk); t0 = cyc;
        @(posedge clk); #1 a_read = 0;
        lat = 0;
        while (!a_full_n && lat < 20) begin
            @(negedge clk); lat = cyc - t0;
        end
        chk("simul_credit_latency", 32'(lat), 32'(A_LEVEL + 1));
        @(negedge clk);
        chk("simul_refull", 32'(a_full_n), 32'(0));

        // Drain.
        @(posedge clk); #1 a_write = 0; a_read = 1;
        repeat (20) @(posedge clk);

        // Full rate: 1000 sequential words with the reader always ready.
        #1 a_write = 1; val = '0; ncyc = 0; acc = 0;
        while (acc < 1000 && ncyc < 1100) begin
            a_din = val;
            @(negedge clk); ncyc++;
            if (a_full_n) begin acc++; val = val + 1; end
            @(posedge clk); #1;
        end
        a_write = 0;
        chk("fullrate_cycles", 32'(ncyc), 32'(1000));
        repeat (20) @(posedge clk);

        // Random traffic with varying reader pressure.
        #1 rd_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) rd_pct = int'($urandom_range(100, 5));
            a_write    = ($urandom_range(99) < 70);
            a_write_ce = ($urandom_range(99) < 90);
            a_din      = $urandom();
            a_read     = (int'($urandom_range(99)) < rd_pct);
            a_read_ce  = ($urandom_range(99) < 90);
            @(posedge clk); #1;
        end
        a_write = 0; a_write_ce = 1; a_read = 1; a_read_ce = 1;
        repeat (30) @(posedge clk);

        // Reset mid-stream with words in flight.
        #1 a_read = 0; a_write = 1;
        for (int i = 0; i < 5; i++) begin
            a_din = 32'(32'h1000 + i);
            @(posedge clk); #1;
        end
        a_write = 0; reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_full_n", 32'(a_full_n), 32'(1));
        chk("rst_empty_n", 32'(a_empty_n), 32'(0));
        chk("rst_count", 32'(a_count), 32'(0));
        @(posedge clk); #1 a_write = 1; acc = 0;
        for (int i = 0; i < 12; i++) begin
            a_din = 32'(32'hA000 + i);
            @(negedge clk); if (a_full_n) acc++;
            @(posedge clk); #1;
        end
        a_write = 0;
        chk("rst_accepted", 32'(acc), 32'(A_CREDITS));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_first_word", a_dout, 32'hA000);
        @(posedge clk); #1 a_read = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'(0));
        chk("final_overflow", 32'(a_err), 32'(0));
        model_en = 1'b0;

        // LEVEL=0 build: one-cycle latency, 4 credits, immediate credit return.
        chk("b_idle_full_n", 32'(b_full_n), 32'(1));
        chk("b_idle_empty_n", 32'(b_empty_n), 32'(0));
        chk("b_idle_count", 32'(b_count), 32'(0));
        @(posedge clk); #1 b_write = 1; b_write_ce = 1; b_read_ce = 1; b_din = 32'h55;
        @(posedge clk); #1 b_write = 0;
        @(negedge clk);
        chk("b_latency_empty_n", 32'(b_empty_n), 32'(1));
        chk("b_latency_dout", b_dout, 32'h55);
        @(posedge clk); #1 b_write = 1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            b_din = 32'(32'h56 + i);
            @(negedge clk); if (b_full_n) acc++;
            @(posedge clk); #1;
        end
        chk("b_bp_accepted", 32'(acc), 32'(B_CREDITS - 1));
        b_read = 1;
        @(posedge clk); #1 b_read = 0;
        @(negedge clk);
        chk("b_credit_back", 32'(b_full_n), 32'(1));
        chk("b_next_word", b_dout, 32'h56);
        @(negedge clk);
        chk("b_refull", 32'(b_full_n), 32'(0));
        chk("b_count_full", 32'(b_count), 32'(B_CREDITS));
        chk("b_overflow", 32'(b_err), 32'(0));
        @(posedge clk); #1 b_write = 0;

        // CONNECT=0 build: everything idle regardless of traffic.
        c_write = 1; c_write_ce = 1; c_read = 1; c_read_ce = 1;
        for (int i = 0; i < 2; i++) begin
            c_din = $urandom();
            @(negedge clk);
            chk("c_full_n", 32'(c_full_n), 32'(0));
            chk("c_empty_n", 32'(c_empty_n), 32'(0));
            chk("c_dout", c_dout, 32'(0));
            chk("c_count", 32'(c_count), 32'(0));
            chk("c_overflow", 32'(c_err), 32'(0));
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
